// File: rtl/cpu6_memarb.sv
// cpu6 shared memory port arbiter: IF vs LS, registered bus request,
// store lane masks, completion and read-data return.
module cpu6_memarb #(
   parameter int ADDR_W      = 32,
   parameter int MAX_DSTREAK = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_ack,
   output logic              ls_err,
   output logic [31:0]       rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wmask,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      BUS_IF,
      BUS_LS,
      ERR
   } state_t;

   localparam logic [3:0] SMAX = 4'(MAX_DSTREAK);

   state_t            state, state_n;
   logic [3:0]        streak, streak_n;
   logic              if_ack_n, ls_ack_n, ls_err_n;
   logic [31:0]       rdata_n;
   logic              mem_req_n, mem_we_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [3:0]        mem_wmask_n;
   logic [31:0]       mem_wdata_n;

   logic              ls_bad;
   logic              ls_win, if_win;
   logic [3:0]        ls_mask;
   logic [31:0]       ls_lane;
   logic              unused_if_lsb;

   assign unused_if_lsb = ^if_addr[1:0];

   assign ls_bad = (ls_size == 2'd3)
                 | ((ls_size == 2'd1) & ls_addr[0])
                 | ((ls_size == 2'd2) & (|ls_addr[1:0]));

   // LS has priority until it has starved a pending fetch MAX_DSTREAK times
   assign ls_win = ls_req & (~if_req | (streak != SMAX));
   assign if_win = if_req & ~ls_win;

   always_comb begin
      ls_mask = 4'b1111;
      ls_lane = ls_wdata;
      unique case (1'b1)
         ls_size == 2'd0: begin
            ls_mask = 4'b0001 << ls_addr[1:0];
            ls_lane = {4{ls_wdata[7:0]}};
         end
         ls_size == 2'd1: begin
            ls_mask = 4'b0011 << ls_addr[1:0];
            ls_lane = {2{ls_wdata[15:0]}};
         end
         default: begin
            ls_mask = 4'b1111;
            ls_lane = ls_wdata;
         end
      endcase
   end

   always_comb begin
      state_n     = state;
      streak_n    = streak;
      if_ack_n    = 1'b0;
      ls_ack_n    = 1'b0;
      ls_err_n    = 1'b0;
      rdata_n     = rdata;
      mem_req_n   = mem_req;
      mem_we_n    = mem_we;
      mem_addr_n  = mem_addr;
      mem_wmask_n = mem_wmask;
      mem_wdata_n = mem_wdata;
      unique case (state)
         IDLE: begin
            if (ls_win) begin
               if (!if_req)
                  streak_n = 4'd0;
               else if (streak != SMAX)
                  streak_n = streak + 4'd1;
               if (ls_bad) begin
                  state_n = ERR;
               end else begin
                  state_n     = BUS_LS;
                  mem_req_n   = 1'b1;
                  mem_we_n    = ls_we;
                  mem_addr_n  = {ls_addr[ADDR_W-1:2], 2'b00};
                  mem_wmask_n = ls_we ? ls_mask : 4'b0000;
                  mem_wdata_n = ls_we ? ls_lane : 32'd0;
               end
            end else if (if_win) begin
               streak_n    = 4'd0;
               state_n     = BUS_IF;
               mem_req_n   = 1'b1;
               mem_we_n    = 1'b0;
               mem_addr_n  = {if_addr[ADDR_W-1:2], 2'b00};
               mem_wmask_n = 4'b0000;
               mem_wdata_n = 32'd0;
            end
         end
         BUS_IF: begin
            if (mem_ack) begin
               state_n   = IDLE;
               mem_req_n = 1'b0;
               rdata_n   = mem_rdata;
               if_ack_n  = 1'b1;
            end
         end
         BUS_LS: begin
            if (mem_ack) begin
               state_n   = IDLE;
               mem_req_n = 1'b0;
               rdata_n   = mem_rdata;
               ls_ack_n  = 1'b1;
            end
         end
         ERR: begin
            state_n  = IDLE;
            ls_ack_n = 1'b1;
            ls_err_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         streak    <= 4'd0;
         if_ack    <= 1'b0;
         ls_ack    <= 1'b0;
         ls_err    <= 1'b0;
         rdata     <= 32'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wmask <= 4'b0000;
         mem_wdata <= 32'd0;
      end else begin
         state     <= state_n;
         streak    <= streak_n;
         if_ack    <= if_ack_n;
         ls_ack    <= ls_ack_n;
         ls_err    <= ls_err_n;
         rdata     <= rdata_n;
         mem_req   <= mem_req_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wmask <= mem_wmask_n;
         mem_wdata <= mem_wdata_n;
      end
   end

endmodule

// File: tb/tb_cpu6_memarb.sv
// Directed bench for cpu6_memarb: LS vector table plus fetch, fairness,
// reset-abort and wait-state sequences.
module tb_cpu6_memarb;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
      logic [3:0]  mask;
      logic [31:0] mwdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [1:0]  ls_size = 2'd0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_ack;
   logic        ls_err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata = '0;

   logic bus_ack = 1'b0;
   logic stray = 1'b0;
   logic ack_en = 1'b0;
   int   waits = 0;
   int   cnt = 0;

   int total = 0;
   int bad = 0;
   logic [31:0] last_rd = '0;

   vec_t vt[11];
   vec_t v6;

   assign mem_ack = bus_ack | stray;

   always #5 clk = ~clk;

   cpu6_memarb #(.ADDR_W(32), .MAX_DSTREAK(4)) dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .ls_err(ls_err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // bus model: mem_req held waits+1 cycles, ack in the last one
   always @(negedge clk) begin
      if (!resetn) begin
         bus_ack <= 1'b0;
         cnt     <= 0;
      end else if (bus_ack) begin
         bus_ack <= 1'b0;
         cnt     <= 0;
      end else if (ack_en && mem_req) begin
         if (cnt == waits)
            bus_ack <= 1'b1;
         else
            cnt <= cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_ls(input vec_t v, input int w);
      int n, reqc, unst, extra;
      bit seen, got;
      logic [31:0] ea;
      ea = {v.addr[31:2], 2'b00};
      waits = w;
      mem_rdata = v.rd;
      ls_we = v.we;
      ls_size = v.size;
      ls_addr = v.addr;
      ls_wdata = v.wdata;
      ls_req = 1'b1;
      n = 0; reqc = 0; unst = 0; seen = 0; got = 0;
      while (!got && n < 40) begin
         tick();
         n++;
         if (mem_req) begin
            reqc++;
            if (mem_addr !== ea || mem_we !== v.we || mem_wmask !== v.mask ||
                (v.we && mem_wdata !== v.mwdata))
               unst++;
            if (!seen) begin
               seen = 1;
               chk("ls_mem_addr", mem_addr, ea);
               chk("ls_mem_we", 32'(mem_we), 32'(v.we));
               chk("ls_mem_wmask", 32'(mem_wmask), 32'(v.mask));
               if (v.we) chk("ls_mem_wdata", mem_wdata, v.mwdata);
            end
         end
         if (ls_ack) begin
            got = 1;
            ls_req = 1'b0;
         end
      end
      ls_req = 1'b0;
      chk("ls_ack_latency", n, v.err ? 2 : w + 2);
      chk("ls_err", 32'(ls_err), 32'(v.err));
      chk("ls_req_cycles", reqc, v.err ? 0 : w + 1);
      chk("ls_fields_stable", unst, 0);
      chk("ls_rdata", rdata, v.err ? last_rd : v.rd);
      if (!v.err && got) last_rd = v.rd;
      extra = 0;
      repeat (4) begin
         tick();
         if (ls_ack || if_ack || mem_req) extra++;
      end
      chk("ls_single_ack", extra, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, nif, nls, lsq, g, quiet;
      bit got, seen, prev;
      logic [9:0] seq;

      vt[0]  = '{1'b1, 2'd0, 32'h203, 32'h000000A5, 32'h0BAD0001, 1'b0, 4'b1000, 32'hA5A5A5A5};
      vt[1]  = '{1'b1, 2'd0, 32'h200, 32'h12345677, 32'h0BAD0002, 1'b0, 4'b0001, 32'h77777777};
      vt[2]  = '{1'b1, 2'd1, 32'h302, 32'hCAFEBEEF, 32'h0BAD0003, 1'b0, 4'b1100, 32'hBEEFBEEF};
      vt[3]  = '{1'b0, 2'd1, 32'h301, 32'h0, 32'hFFFF0001, 1'b1, 4'b0000, 32'h0};
      vt[4]  = '{1'b0, 2'd2, 32'h302, 32'h0, 32'hFFFF0002, 1'b1, 4'b0000, 32'h0};
      vt[5]  = '{1'b0, 2'd2, 32'h040, 32'h0, 32'h11223344, 1'b0, 4'b0000, 32'h0};
      vt[6]  = '{1'b1, 2'd3, 32'h000, 32'h5, 32'hFFFF0003, 1'b1, 4'b0000, 32'h0};
      vt[7]  = '{1'b0, 2'd0, 32'h007, 32'h0, 32'h000055AA, 1'b0, 4'b0000, 32'h0};
      vt[8]  = '{1'b1, 2'd2, 32'h044, 32'hDEADBEEF, 32'h00000001, 1'b0, 4'b1111, 32'hDEADBEEF};
      vt[9]  = '{1'b1, 2'd1, 32'h003, 32'h1234, 32'hFFFF0004, 1'b1, 4'b0000, 32'h0};
      vt[10] = '{1'b1, 2'd0, 32'h002, 32'h0000003C, 32'h00000002, 1'b0, 4'b0100, 32'h3C3C3C3C};
      v6     = '{1'b1, 2'd2, 32'h040, 32'hDEADBEEF, 32'h00000099, 1'b0, 4'b1111, 32'hDEADBEEF};

      #2;
      chk("rst_ctrl", 32'({if_ack, ls_ack, ls_err, mem_req, mem_we, mem_wmask}), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      tick();
      ack_en = 1'b1;
      waits = 0;

      // fetch only
      if_addr = 32'h100;
      mem_rdata = 32'h00000013;
      if_req = 1'b1;
      n = 0; got = 0; seen = 0; lsq = 0;
      while (!got && n < 40) begin
         tick();
         n++;
         if (ls_ack) lsq++;
         if (mem_req && !seen) begin
            seen = 1;
            chk("if_mem_addr", mem_addr, 32'h100);
            chk("if_mem_we", 32'(mem_we), 32'h0);
            chk("if_mem_wmask", 32'(mem_wmask), 32'h0);
         end
         if (if_ack) begin
            got = 1;
            if_req = 1'b0;
         end
      end
      if_req = 1'b0;
      chk("if_ack_latency", n, 2);
      chk("if_rdata", rdata, 32'h13);
      chk("if_no_ls_ack", lsq, 0);
      last_rd = 32'h13;
      tick();
      chk("if_ack_pulse", 32'(if_ack), 32'h0);

      for (int i = 0; i < 11; i++)
         run_ls(vt[i], 0);

      // fairness: both requesters continuously busy
      waits = 0;
      mem_rdata = 32'h77;
      if_addr = 32'h500;
      ls_we = 1'b0;
      ls_size = 2'd2;
      ls_addr = 32'h80;
      if_req = 1'b1;
      ls_req = 1'b1;
      seq = '0; g = 0; n = 0; nif = 0; nls = 0; prev = 0;
      while (g < 10 && n < 200) begin
         tick();
         n++;
         if (if_ack) nif++;
         if (ls_ack) nls++;
         if (mem_req && !prev) begin
            seq[g] = (mem_addr == 32'h500);
            g++;
         end
         prev = mem_req;
      end
      while (nif < 2 && n < 200) begin
         tick();
         n++;
         if (if_ack) nif++;
         if (ls_ack) nls++;
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      chk("streak_grant_order", 32'(seq), 32'h210);
      chk("streak_if_acks", nif, 2);
      chk("streak_ls_acks", nls, 8);
      tick();
      tick();
      chk("streak_drained", 32'(mem_req), 32'h0);
      last_rd = 32'h77;

      run_ls(v6, 5);

      // reset while a fetch is on the bus
      ack_en = 1'b0;
      if_addr = 32'h600;
      if_req = 1'b1;
      n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      chk("abort_req_up", 32'(mem_req), 32'h1);
      #2 resetn = 1'b0;
      if_req = 1'b0;
      #1;
      chk("abort_ctrl", 32'({if_ack, ls_ack, ls_err, mem_req, mem_we, mem_wmask}), 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      chk("abort_rdata", rdata, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      tick();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      quiet = 0;
      repeat (5) begin
         tick();
         if (if_ack || ls_ack || mem_req) quiet++;
      end
      chk("abort_stray_ignored", quiet, 0);
      last_rd = 32'h0;
      ack_en = 1'b1;
      run_ls(vt[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
